// File: rtl/bch_wrapper_ecc_reader.sv
// bch_wrapper_ecc_reader
// Fetches the stored BCH ECC words from external memory, reassembles the ECC
// vector and streams data bits then ECC bits (MSB first) to the decoder input.
// Optional feature macro: BCH_WRAPPER_PAD_CHECK_EN adds O_fmt_err, which flags
// nonzero pad bits above the ECC field in the top memory word.
module bch_wrapper_ecc_reader #(
    parameter int C_DATA_BITS     = 16,
    parameter int C_ECC_BITS      = 20,
    parameter int C_BITS          = 1,
    parameter int C_I_MEMADDR     = 0,
    parameter int C_MEM_ADDR_SIZE = 10,
    parameter int C_MEM_DATA_SIZE = 8
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic                       I_en,
    input  logic [C_DATA_BITS-1:0]     I_data,
    input  logic                       I_start,
    output logic [C_MEM_ADDR_SIZE-1:0] O_mem_raddr,
    output logic                       O_ren,
    input  logic [C_MEM_DATA_SIZE-1:0] I_mem_rdata,
    output logic                       O_cw_valid,
    output logic [C_BITS-1:0]          O_cw_data,
    output logic                       O_cw_first,
    output logic                       O_cw_last,
    input  logic                       I_cw_ready,
    output logic                       O_busy,
    output logic                       O_ready
`ifdef BCH_WRAPPER_PAD_CHECK_EN
    ,
    output logic                       O_fmt_err
`endif
);

    localparam int LP_MEM_WORDS = C_ECC_BITS / C_MEM_DATA_SIZE + 1;
    localparam int LP_BUF_BITS  = LP_MEM_WORDS * C_MEM_DATA_SIZE;
    localparam int LP_CW_BITS   = C_DATA_BITS + C_ECC_BITS;
    localparam int LP_BEATS     = LP_CW_BITS / C_BITS;
    localparam int LP_CNT_W     = $clog2(LP_MEM_WORDS + 1);
    localparam int LP_BEAT_W    = $clog2(LP_BEATS + 1);
    localparam logic [C_MEM_ADDR_SIZE-1:0] LP_BASE = C_MEM_ADDR_SIZE'(C_I_MEMADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    start_d_r;
    logic [C_DATA_BITS-1:0]  data_r;
    logic [LP_BUF_BITS-1:0]  ecc_buf_r;
    logic [LP_CNT_W-1:0]     fetch_cnt_r;
    logic [LP_BEAT_W-1:0]    beat_cnt_r;
    logic [LP_CW_BITS-1:0]   shreg_r;
    logic                    start_edge_s;
    logic [LP_BUF_BITS-1:0]  ecc_full_s;

`ifdef BCH_WRAPPER_PAD_CHECK_EN
    localparam logic [LP_BUF_BITS-1:0] LP_PAD_MASK =
        ~((LP_BUF_BITS'(1) << C_ECC_BITS) - LP_BUF_BITS'(1));

    // Any set bit above the ECC field marks a malformed stored word.
    function automatic logic pad_nonzero(input logic [LP_BUF_BITS-1:0] buf_v);
        pad_nonzero = |(buf_v & LP_PAD_MASK);
    endfunction
`else
    logic unused_pad_s;
    assign unused_pad_s = ^ecc_full_s[LP_BUF_BITS-1:C_ECC_BITS];
`endif

    assign start_edge_s = I_start & ~start_d_r;
    assign O_cw_data    = shreg_r[LP_CW_BITS-1 -: C_BITS];

    // Full ECC vector as it will look once the top word arriving now is captured.
    always_comb begin
        ecc_full_s = ecc_buf_r;
        ecc_full_s[(LP_MEM_WORDS-1)*C_MEM_DATA_SIZE +: C_MEM_DATA_SIZE] = I_mem_rdata;
    end

    // Control FSM with registered memory, stream and status outputs.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_r     <= ST_IDLE;
            start_d_r   <= 1'b0;
            data_r      <= '0;
            ecc_buf_r   <= '0;
            fetch_cnt_r <= '0;
            beat_cnt_r  <= '0;
            shreg_r     <= '0;
            O_mem_raddr <= LP_BASE;
            O_ren       <= 1'b0;
            O_cw_valid  <= 1'b0;
            O_cw_first  <= 1'b0;
            O_cw_last   <= 1'b0;
            O_busy      <= 1'b0;
            O_ready     <= 1'b0;
`ifdef BCH_WRAPPER_PAD_CHECK_EN
            O_fmt_err   <= 1'b0;
`endif
        end else begin
            // Tracks I_start even when disabled so a held start never re-fires.
            start_d_r <= I_start;
            if (!I_en) begin
                state_r     <= ST_IDLE;
                data_r      <= '0;
                ecc_buf_r   <= '0;
                fetch_cnt_r <= '0;
                beat_cnt_r  <= '0;
                shreg_r     <= '0;
                O_mem_raddr <= LP_BASE;
                O_ren       <= 1'b0;
                O_cw_valid  <= 1'b0;
                O_cw_first  <= 1'b0;
                O_cw_last   <= 1'b0;
                O_busy      <= 1'b0;
                O_ready     <= 1'b0;
`ifdef BCH_WRAPPER_PAD_CHECK_EN
                O_fmt_err   <= 1'b0;
`endif
            end else begin
                O_ready <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (start_edge_s) begin
                            data_r      <= I_data;
                            ecc_buf_r   <= '0;
                            fetch_cnt_r <= '0;
                            O_busy      <= 1'b1;
                            O_ren       <= 1'b1;
                            O_mem_raddr <= LP_BASE;
`ifdef BCH_WRAPPER_PAD_CHECK_EN
                            O_fmt_err   <= 1'b0;
`endif
                            state_r     <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // Word k returns while fetch_cnt_r == k+1.
                        for (int k = 0; k < LP_MEM_WORDS; k++) begin
                            if (fetch_cnt_r == LP_CNT_W'(k + 1)) begin
                                ecc_buf_r[k*C_MEM_DATA_SIZE +: C_MEM_DATA_SIZE] <= I_mem_rdata;
                            end
                        end
                        if (fetch_cnt_r == LP_CNT_W'(LP_MEM_WORDS)) begin
                            shreg_r     <= {data_r, ecc_full_s[C_ECC_BITS-1:0]};
                            beat_cnt_r  <= '0;
                            fetch_cnt_r <= '0;
                            O_cw_valid  <= 1'b1;
                            O_cw_first  <= 1'b1;
                            O_cw_last   <= (LP_BEATS == 1);
`ifdef BCH_WRAPPER_PAD_CHECK_EN
                            if (pad_nonzero(ecc_full_s)) begin
                                O_fmt_err <= 1'b1;
                            end
`endif
                            state_r     <= ST_STREAM;
                        end else begin
                            fetch_cnt_r <= fetch_cnt_r + LP_CNT_W'(1);
                            if (fetch_cnt_r < LP_CNT_W'(LP_MEM_WORDS - 1)) begin
                                O_ren       <= 1'b1;
                                O_mem_raddr <= O_mem_raddr + C_MEM_ADDR_SIZE'(1);
                            end else begin
                                O_ren <= 1'b0;
                            end
                        end
                    end
                    ST_STREAM: begin
                        if (O_cw_valid && I_cw_ready) begin
                            if (O_cw_last) begin
                                O_cw_valid <= 1'b0;
                                O_cw_first <= 1'b0;
                                O_cw_last  <= 1'b0;
                                shreg_r    <= '0;
                                beat_cnt_r <= '0;
                                O_ready    <= 1'b1;
                                O_busy     <= 1'b0;
                                state_r    <= ST_DONE;
                            end else begin
                                shreg_r    <= {shreg_r[LP_CW_BITS-C_BITS-1:0], {C_BITS{1'b0}}};
                                beat_cnt_r <= beat_cnt_r + LP_BEAT_W'(1);
                                O_cw_first <= 1'b0;
                                O_cw_last  <= (beat_cnt_r == LP_BEAT_W'(LP_BEATS - 2));
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bch_wrapper_ecc_reader.sv
// Directed bench for bch_wrapper_ecc_reader (16 data bits, 20 ECC bits, 1-bit beats).
module tb_bch_wrapper_ecc_reader;

    localparam logic [35:0] EXP_CW = {16'hBEEF, 20'hFA53C};

    logic       I_clk;
    logic       I_rst;
    logic       I_en;
    logic [15:0] I_data;
    logic       I_start;
    logic [9:0] O_mem_raddr;
    logic       O_ren;
    logic [7:0] I_mem_rdata;
    logic       O_cw_valid;
    logic [0:0] O_cw_data;
    logic       O_cw_first;
    logic       O_cw_last;
    logic       I_cw_ready;
    logic       O_busy;
    logic       O_ready;
`ifdef BCH_WRAPPER_PAD_CHECK_EN
    logic       O_fmt_err;
`endif

    bch_wrapper_ecc_reader dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_en        (I_en),
        .I_data      (I_data),
        .I_start     (I_start),
        .O_mem_raddr (O_mem_raddr),
        .O_ren       (O_ren),
        .I_mem_rdata (I_mem_rdata),
        .O_cw_valid  (O_cw_valid),
        .O_cw_data   (O_cw_data),
        .O_cw_first  (O_cw_first),
        .O_cw_last   (O_cw_last),
        .I_cw_ready  (I_cw_ready),
        .O_busy      (O_busy),
        .O_ready     (O_ready)
`ifdef BCH_WRAPPER_PAD_CHECK_EN
        ,
        .O_fmt_err   (O_fmt_err)
`endif
    );

    logic [7:0] mem [1024];

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt, rd_addr [8], ready_cnt, ready_cyc, first_valid_cyc;
    int beats_got, first_cnt, first_idx, last_cnt, last_idx, last_cyc;
    logic beat_bits [64];

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    // Memory model: read data appears one cycle after the strobe.
    always @(posedge I_clk) begin
        if (O_ren) I_mem_rdata <= mem[O_mem_raddr];
        else       I_mem_rdata <= 8'h00;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expbit(input int i);
        logic [35:0] e;
        e = EXP_CW;
        return e[35-i];
    endfunction

    task automatic clear_log();
        rd_cnt = 0; ready_cnt = 0; ready_cyc = -1; first_valid_cyc = -1;
        beats_got = 0; first_cnt = 0; first_idx = -1; last_cnt = 0; last_idx = -1; last_cyc = -1;
    endtask

    task automatic tick();
        @(negedge I_clk);
        cyc++;
        if (O_ren) begin
            if (rd_cnt < 8) rd_addr[rd_cnt] = int'(O_mem_raddr);
            rd_cnt++;
        end
        if (O_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (O_cw_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            check("busy_in_stream", 64'(O_busy), 64'd1);
        end
    endtask

    task automatic record_beat();
        if (O_cw_valid && I_cw_ready) begin
            if (beats_got < 64) beat_bits[beats_got] = O_cw_data[0];
            if (O_cw_first) begin first_cnt++; first_idx = beats_got; end
            if (O_cw_last)  begin last_cnt++;  last_idx = beats_got; last_cyc = cyc; end
            beats_got++;
        end
    endtask

    // One codeword request with optional stall, held start, mid-stream edge or async reset.
    task automatic run_cw(input int stall_at, input int hold_len, input bit pulse_mid, input int rst_at);
        int start_cyc, stall_rem, pulse_st;
        bit stalled;
        logic [35:0] got;
        clear_log();
        stall_rem = 0; stalled = 1'b0; pulse_st = 0;
        I_cw_ready = 1'b1;
        I_start = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (k == hold_len) I_start = 1'b0;
            if (pulse_mid && pulse_st == 1) begin I_start = 1'b0; pulse_st = 2; end
            if (pulse_mid && pulse_st == 0 && beats_got == 20) begin I_start = 1'b1; pulse_st = 1; end
            if (rst_at >= 0 && beats_got == rst_at) begin
                #2 I_rst = 1'b1;
                #1;
                check("arst_valid", 64'(O_cw_valid), 64'd0);
                check("arst_busy", 64'(O_busy), 64'd0);
                tick();
                I_rst = 1'b0;
                tick();
                return;
            end
            if (!stalled && stall_at >= 0 && beats_got == stall_at && O_cw_valid) begin
                stalled = 1'b1;
                stall_rem = 5;
            end
            if (stall_rem > 0) begin
                I_cw_ready = 1'b0;
                check("bp_valid", 64'(O_cw_valid), 64'd1);
                check("bp_data", 64'(O_cw_data), 64'(expbit(stall_at)));
                stall_rem--;
            end else begin
                I_cw_ready = 1'b1;
            end
            record_beat();
        end
        got = '0;
        for (int i = 0; i < 36; i++) got[35-i] = beat_bits[i];
        check("read_count", 64'(rd_cnt), 64'd3);
        check("read_addr0", 64'(rd_addr[0]), 64'd0);
        check("read_addr1", 64'(rd_addr[1]), 64'd1);
        check("read_addr2", 64'(rd_addr[2]), 64'd2);
        check("beat_count", 64'(beats_got), 64'd36);
        check("beat_seq", 64'(got), 64'(EXP_CW));
        check("first_count", 64'(first_cnt), 64'd1);
        check("first_idx", 64'(first_idx), 64'd0);
        check("last_count", 64'(last_cnt), 64'd1);
        check("last_idx", 64'(last_idx), 64'd35);
        check("ready_count", 64'(ready_cnt), 64'd1);
        check("ready_latency", 64'(ready_cyc - last_cyc), 64'd1);
        check("valid_latency", 64'(first_valid_cyc - start_cyc), 64'd5);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h3C; mem[1] = 8'hA5; mem[2] = 8'h0F;
        I_rst = 1'b1; I_en = 1'b1; I_data = 16'hBEEF; I_start = 1'b0; I_cw_ready = 1'b1;
        clear_log();
        tick(); tick();
        I_rst = 1'b0;
        tick();
        check("rst_valid", 64'(O_cw_valid), 64'd0);
        check("rst_busy", 64'(O_busy), 64'd0);
        check("rst_ren", 64'(O_ren), 64'd0);
        check("rst_raddr", 64'(O_mem_raddr), 64'd0);
        check("rst_ready", 64'(O_ready), 64'd0);
        check("rst_first", 64'(O_cw_first), 64'd0);
        check("rst_last", 64'(O_cw_last), 64'd0);
        check("rst_data", 64'(O_cw_data), 64'd0);
`ifdef BCH_WRAPPER_PAD_CHECK_EN
        check("rst_fmt_err", 64'(O_fmt_err), 64'd0);
`endif

        // Basic read
        run_cw(-1, 0, 1'b0, -1);
        // Backpressure at beat 10
        run_cw(10, 0, 1'b0, -1);
        // Start held high for 100 cycles
        run_cw(-1, 100, 1'b0, -1);
        // Second start edge during STREAM
        run_cw(-1, 0, 1'b1, -1);

        // Disable during fetch of word 1
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        tick();
        check("dis_pre_raddr", 64'(O_mem_raddr), 64'd1);
        I_en = 1'b0;
        tick();
        check("dis_ren", 64'(O_ren), 64'd0);
        check("dis_raddr", 64'(O_mem_raddr), 64'd0);
        check("dis_busy", 64'(O_busy), 64'd0);
        check("dis_valid", 64'(O_cw_valid), 64'd0);
        I_en = 1'b1;
        tick();
        run_cw(-1, 0, 1'b0, -1);

        // Async reset between edges during STREAM
        run_cw(-1, 0, 1'b0, 8);
        run_cw(-1, 0, 1'b0, -1);

`ifdef BCH_WRAPPER_PAD_CHECK_EN
        mem[2] = 8'h1F;
        run_cw(-1, 0, 1'b0, -1);
        check("pad_fmt_err_set", 64'(O_fmt_err), 64'd1);
        mem[2] = 8'h0F;
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        tick();
        check("pad_fmt_err_clr", 64'(O_fmt_err), 64'd0);
        for (int k = 0; k < 60; k++) tick();
        check("pad_fmt_err_stay_clr", 64'(O_fmt_err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bch_wrapper_ecc_reader.md
# bch_wrapper_ecc_reader

Reads back the ECC bits that the BCH encoder wrapper stored in external memory, reassembles them, and streams the full codeword (data bits, then ECC bits) into the BCH decoder input port. It is the memory-reader and serializer front end of the decoder wrapper. It sits between the shared ECC RAM and the syndrome stage.

## Interface
- C_DATA_BITS, 16: data bits per codeword; the parent sets it from `BCH_DATA_BITS(C_P)`.
- C_ECC_BITS, 20: ECC bits per codeword; the parent sets it from `BCH_ECC_BITS(C_P)`.
- C_BITS, 1: bits per stream beat; must divide both C_DATA_BITS and C_ECC_BITS.
- C_I_MEMADDR, 0: base address of the stored ECC words.
- C_MEM_ADDR_SIZE, 10: memory address width.
- C_MEM_DATA_SIZE, 8: memory word width.
- Derived: LP_MEM_WORDS = C_ECC_BITS / C_MEM_DATA_SIZE + 1. This matches the writer's layout.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  reset, asynchronous, active-high.
- I_en  in  1  synchronous enable; low forces IDLE and reset values.
- I_data  in  C_DATA_BITS  received data word; latched on accepted start.
- I_start  in  1  rising edge requests one codeword.
- O_mem_raddr  out  C_MEM_ADDR_SIZE  read address.
- O_ren  out  1  read strobe.
- I_mem_rdata  in  C_MEM_DATA_SIZE  read data; valid exactly 1 cycle after O_ren.
- O_cw_valid  out  1  stream beat valid.
- O_cw_data  out  C_BITS  beat payload; the MSB is the earliest bit.
- O_cw_first  out  1  first beat of the codeword.
- O_cw_last  out  1  last beat of the codeword.
- I_cw_ready  in  1  decoder accepts the beat.
- O_busy  out  1  a codeword is in progress.
- O_ready  out  1  one-cycle pulse when the codeword has been fully streamed.
- O_fmt_err  out  1  pad-bit error flag; present only with the macro (see Configuration).

## Operation
- Memory layout: word k at C_I_MEMADDR+k holds ecc[k·W+W-1 : k·W], where W = C_MEM_DATA_SIZE.
  - The ECC MSB is the first ECC bit sent on the stream.
  - Bits above C_ECC_BITS-1 in the top word are pad bits and are ignored.
- FSM states: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - A rising edge on I_start is detected against a registered copy of I_start.
  - On that edge: latch I_data, assert O_busy, go to FETCH.
  - Edges seen outside IDLE are ignored; they are not queued.
- FETCH:
  - Issue LP_MEM_WORDS consecutive reads on consecutive cycles, with O_ren=1 and addresses C_I_MEMADDR … C_I_MEMADDR+LP_MEM_WORDS-1.
  - Capture each returned word one cycle later into ecc_buf at bit offset k·W.
  - After the last word is captured, go to STREAM.
  - The address counter wraps modulo 2^C_MEM_ADDR_SIZE.
- STREAM:
  - Send C_DATA_BITS/C_BITS data beats, then C_ECC_BITS/C_BITS ECC beats.
  - The beat shift register advances only when O_cw_valid && I_cw_ready.
  - O_cw_valid stays high and O_cw_data stays stable while I_cw_ready is low.
  - O_cw_first is high only on beat 0. O_cw_last is high only on the final beat.
  - When the last beat is accepted, go to DONE.
- DONE: pulse O_ready for 1 cycle, clear O_busy, return to IDLE.
- I_en low, at any state, on a clock edge: go to IDLE, clear buffers and counters, drive all outputs to their reset values.
- Asynchronous reset: same values as I_en low, applied immediately.

## Timing
- Reset values: O_mem_raddr = C_I_MEMADDR; all other outputs = 0.
- Start-edge detection costs 1 cycle. FETCH starts the cycle after the edge is seen.
- FETCH takes LP_MEM_WORDS+1 cycles: the reads plus the trailing capture cycle.
- The first O_cw_valid rises on the cycle after FETCH ends.
- With I_cw_ready held high, STREAM takes (C_DATA_BITS+C_ECC_BITS)/C_BITS cycles.
- O_ready follows the last accepted beat by exactly 1 cycle.
- All outputs are registered. There are no combinational paths from I_cw_ready to O_cw_valid or O_cw_data.
- I_start held high continuously produces only one request until it is deasserted.

## Configuration
- Macro BCH_WRAPPER_PAD_CHECK_EN.
- Defined:
  - Pad bits of the top word are checked against zero when that word is captured.
  - A nonzero pad sets O_fmt_err. It stays set until the next accepted start, I_en low, or I_rst.
  - Streaming proceeds regardless of the flag.
- Undefined: the O_fmt_err port and the check logic are absent; pad bits are never inspected.

## Test plan
- Basic read (C_BITS=1, W=8, 16/20 bits): memory {0x3C, 0xA5, 0x0F}, I_data=0xBEEF.
  - Required: 3 reads at addresses 0,1,2; 36 beats equal to 0xBEEF MSB-first, then 0xFA53C MSB-first.
  - Required: first on beat 0, last on beat 35, O_ready 1 cycle later.
- Backpressure: hold I_cw_ready low 5 cycles at beat 10.
  - Required: O_cw_valid and O_cw_data stay constant; the beat sequence is identical to the basic read.
- Start handling: I_start held high for 100 cycles, and a second edge pulsed during STREAM.
  - Required: exactly one codeword and one O_ready pulse.
- Disable mid-operation: I_en low during FETCH word 1, then a fresh start.
  - Required: outputs at reset values the next cycle; the restart rereads from address C_I_MEMADDR.
- Async reset: I_rst asserted between clock edges in STREAM.
  - Required: O_cw_valid=0 and O_busy=0 immediately, without waiting for a clock edge.
- BCH_WRAPPER_PAD_CHECK_EN defined: top word 0x1F.
  - Required: O_fmt_err=1, all 36 beats still streamed; O_fmt_err clears on the next accepted start.
